// File: rtl/edge_detector_multi.sv
// Multi-channel synchronised, debounced edge detector with per-channel
// edge selection, sticky pending flags and saturating event counters.
module edge_detector_multi #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                            in_clock,
    input  logic                            in_reset,
    input  logic [CHANNELS-1:0]             in_signal,
    input  logic [2*CHANNELS-1:0]           in_mode,
    input  logic [CHANNELS-1:0]             in_clear,
    output logic [CHANNELS-1:0]             out_level,
    output logic [CHANNELS-1:0]             out_strobe,
    output logic [CHANNELS-1:0]             out_pending,
    output logic [CHANNELS*COUNT_WIDTH-1:0] out_count,
    output logic                            out_any
);

    localparam int                     DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + COUNT_WIDTH'(1);
        end
    endfunction

    // new_level is the level being accepted: 1 means a rising edge
    function automatic logic edge_qualifies(input logic [1:0] mode, input logic new_level);
        case (mode)
            2'b01:   edge_qualifies = new_level;
            2'b10:   edge_qualifies = ~new_level;
            2'b11:   edge_qualifies = 1'b1;
            default: edge_qualifies = 1'b0;
        endcase
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DB_W-1:0]        r_db_cnt;
        logic                   r_level;
        logic                   r_strobe;
        logic                   r_pending;
        logic [COUNT_WIDTH-1:0] r_count;

        logic                   w_s;
        logic                   w_accept;
        logic                   w_fire;
        logic [DB_W-1:0]        w_db_next;
        logic                   w_pending_next;
        logic [COUNT_WIDTH-1:0] w_count_base;
        logic [COUNT_WIDTH-1:0] w_count_next;

        assign w_s = r_sync[SYNC_STAGES-1];

        // Debounce: a differing level must persist DEBOUNCE_CYCLES edges to be accepted
        always_comb begin
            w_accept  = 1'b0;
            w_db_next = r_db_cnt;
            if (w_s == r_level) begin
                w_db_next = {DB_W{1'b0}};
            end else if (r_db_cnt == DB_LAST) begin
                w_accept  = 1'b1;
                w_db_next = {DB_W{1'b0}};
            end else begin
                w_db_next = r_db_cnt + DB_W'(1);
            end
        end

        // Event bookkeeping; a clear coincident with an event still records that event
        always_comb begin
            w_fire         = w_accept & edge_qualifies(in_mode[2*g +: 2], w_s);
            w_pending_next = w_fire | (r_pending & ~in_clear[g]);
            if (in_clear[g]) begin
                w_count_base = {COUNT_WIDTH{1'b0}};
            end else begin
                w_count_base = r_count;
            end
            if (w_fire) begin
                w_count_next = sat_inc(w_count_base);
            end else begin
                w_count_next = w_count_base;
            end
        end

        // Channel state registers with synchronous reset
        always_ff @(posedge in_clock) begin
            if (in_reset) begin
                r_sync    <= {SYNC_STAGES{1'b0}};
                r_db_cnt  <= {DB_W{1'b0}};
                r_level   <= 1'b0;
                r_strobe  <= 1'b0;
                r_pending <= 1'b0;
                r_count   <= {COUNT_WIDTH{1'b0}};
            end else begin
                r_sync    <= {r_sync[SYNC_STAGES-2:0], in_signal[g]};
                r_db_cnt  <= w_db_next;
                r_level   <= w_accept ? w_s : r_level;
                r_strobe  <= w_fire;
                r_pending <= w_pending_next;
                r_count   <= w_count_next;
            end
        end

        assign out_level[g]                              = r_level;
        assign out_strobe[g]                             = r_strobe;
        assign out_pending[g]                            = r_pending;
        assign out_count[g*COUNT_WIDTH +: COUNT_WIDTH]   = r_count;
    end

    assign out_any = |out_pending;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: table-driven edge vectors scored through an
// expectation queue, plus hand-written reset, clear and saturation sequences.
module tb_edge_detector_multi;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  sig, clr, lvl, stb, pnd;
    logic [7:0]  mode;
    logic [31:0] cnt;
    logic        any;

    logic        sig2, clr2, lvl2, stb2, pnd2, any2;
    logic [1:0]  mode2;
    logic [1:0]  cnt2;

    edge_detector_multi dut (
        .in_clock(clk), .in_reset(rst), .in_signal(sig), .in_mode(mode), .in_clear(clr),
        .out_level(lvl), .out_strobe(stb), .out_pending(pnd), .out_count(cnt), .out_any(any)
    );

    edge_detector_multi #(.CHANNELS(1), .COUNT_WIDTH(2)) dut2 (
        .in_clock(clk), .in_reset(rst), .in_signal(sig2), .in_mode(mode2), .in_clear(clr2),
        .out_level(lvl2), .out_strobe(stb2), .out_pending(pnd2), .out_count(cnt2), .out_any(any2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int due; int ch; logic strobe; logic level; int count; } exp_t;
    typedef struct { int ch; logic [1:0] md; logic val; int hold; logic strobe; logic level; } vec_t;

    exp_t       q[$];
    vec_t       tbl[$];
    logic [3:0] exp_pending;
    int         exp_cnt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic check_cycle();
        logic [3:0] mask;
        exp_t       e;
        mask = 4'b0000;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("due_cycle", e.due, cyc);
            chk($sformatf("level_ch%0d", e.ch), lvl[e.ch], e.level);
            chk($sformatf("count_ch%0d", e.ch), cnt[e.ch*8 +: 8], e.count);
            if (e.strobe) begin
                mask[e.ch]         = 1'b1;
                exp_pending[e.ch]  = 1'b1;
            end
        end
        chk("strobe", stb, mask);
        chk("pending", pnd, exp_pending);
        chk("any", any, |exp_pending);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_cycle();
        end
    endtask

    task automatic expect_edge(input int ch, input logic level, input logic strobe);
        exp_t e;
        if (strobe) exp_cnt[ch]++;
        e.due = cyc + LAT; e.ch = ch; e.strobe = strobe; e.level = level; e.count = exp_cnt[ch];
        q.push_back(e);
    endtask

    task automatic clear_model();
        q.delete();
        exp_pending = 4'b0000;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
    endtask

    function automatic void add_vec(input int ch, input logic [1:0] md, input logic val,
                                    input int hold, input logic strobe, input logic level);
        vec_t v;
        v.ch = ch; v.md = md; v.val = val; v.hold = hold; v.strobe = strobe; v.level = level;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; sig = 4'b0000; clr = 4'b0000; mode = 8'h00;
        sig2 = 1'b0; clr2 = 1'b0; mode2 = 2'b01;
        clear_model();

        add_vec(0, 2'b01, 1'b1, 10, 1'b1, 1'b1);   // basic rising edge
        add_vec(1, 2'b01, 1'b1, 3,  1'b0, 1'b0);   // 3-cycle glitch: ignored
        add_vec(1, 2'b01, 1'b0, 10, 1'b0, 1'b0);
        add_vec(1, 2'b01, 1'b1, 4,  1'b1, 1'b1);   // exactly DEBOUNCE_CYCLES: accepted
        add_vec(1, 2'b01, 1'b0, 10, 1'b0, 1'b0);   // falling edge in rising mode
        add_vec(0, 2'b00, 1'b0, 10, 1'b0, 1'b0);   // mode off: level tracks only
        for (int k = 0; k < 10; k++) add_vec(2, 2'b11, (k % 2 == 0), 20, 1'b1, (k % 2 == 0));
        for (int k = 0; k < 10; k++) add_vec(2, 2'b10, (k % 2 == 0), 20, (k % 2 != 0), (k % 2 == 0));

        // reset state
        step(2);
        rst = 1'b0;
        chk("reset_level", lvl, 4'b0000);
        chk("reset_count", cnt, 32'h0);

        foreach (tbl[k]) begin
            mode[2*tbl[k].ch +: 2] = tbl[k].md;
            sig[tbl[k].ch]         = tbl[k].val;
            expect_edge(tbl[k].ch, tbl[k].level, tbl[k].strobe);
            step(tbl[k].hold);
        end
        step(LAT + 2);
        chk("count_ch2_total", cnt[23:16], 32'd15);

        // all channels rising together after a fresh reset
        rst = 1'b1; clear_model(); step(2); rst = 1'b0;
        mode = 8'h55; sig = 4'b1111;
        for (int c = 0; c < 4; c++) expect_edge(c, 1'b1, 1'b1);
        step(LAT + 2);
        sig = 4'b0000;
        for (int c = 0; c < 4; c++) expect_edge(c, 1'b0, 1'b0);
        step(LAT + 2);

        // reset mid-debounce wipes everything; held input reported after release
        sig[0] = 1'b1;
        step(4);
        rst = 1'b1; clear_model();
        step(1);
        chk("midreset_level", lvl, 4'b0000);
        chk("midreset_count", cnt, 32'h0);
        step(1);
        rst = 1'b0;
        expect_edge(0, 1'b1, 1'b1);
        step(LAT + 2);

        // clear alone
        clr[0] = 1'b1; exp_pending[0] = 1'b0; exp_cnt[0] = 0;
        step(1);
        clr[0] = 1'b0;
        chk("clear_count0", cnt[7:0], 32'd0);

        // saturation on the 2-bit counter instance
        for (int k = 1; k <= 5; k++) begin
            sig2 = 1'b1;
            step(LAT);
            chk($sformatf("sat_strobe_%0d", k), stb2, 1'b1);
            chk($sformatf("sat_count_%0d", k), cnt2, (k > 3) ? 2'd3 : 2'(k));
            step(2);
            sig2 = 1'b0;
            step(8);
            chk($sformatf("sat_quiet_%0d", k), stb2, 1'b0);
        end
        // clear coincident with the strobe-generating edge keeps the event
        sig2 = 1'b1;
        step(LAT - 1);
        clr2 = 1'b1;
        step(1);
        clr2 = 1'b0;
        chk("clrcoinc_strobe", stb2, 1'b1);
        chk("clrcoinc_pending", pnd2, 1'b1);
        chk("clrcoinc_count", cnt2, 2'd1);
        chk("clrcoinc_any", any2, 1'b1);
        step(1);
        chk("clrcoinc_strobe_off", stb2, 1'b0);

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
